// File: rtl/data_mem_responder.sv
// Data-port memory responder: post-reset clearing sweep, one-cycle registered reads,
// sticky misalign/range flags and saturating access counters.
module data_mem_responder #(
    parameter int unsigned AW = 6,
    parameter int unsigned CW = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          MemWrite,
    input  logic          MemRead,
    input  logic [31:0]   Addr,
    input  logic [31:0]   Wdata,
    output logic [31:0]   Data,
    output logic          Data_Valid,
    output logic          Busy,
    output logic          Misalign,
    output logic          Range_Err,
    output logic [CW-1:0] Wr_Count,
    output logic [CW-1:0] Rd_Count
);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_ptr;
    logic [31:0]   r_mem [2**AW];
    logic [31:0]   r_data;
    logic          r_valid;
    logic          r_mis;
    logic          r_rng;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;

    logic [AW-1:0] w_idx;
    logic          w_misalign;
    logic          w_range;
    logic          w_err;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_idx;
    logic [31:0]   w_mem_wdata;
    logic          w_wr_ok;
    logic          w_rd_go;
    logic          w_flag_upd;

    assign w_idx      = Addr[AW+1:2];
    assign w_misalign = |Addr[1:0];
    assign w_range    = |Addr[31:AW+2];
    assign w_err      = w_misalign | w_range;

    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_idx    = r_clr_ptr;
        w_mem_wdata  = '0;
        w_wr_ok      = 1'b0;
        w_rd_go      = 1'b0;
        w_flag_upd   = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_mem_we = 1'b1;
                if (r_clr_ptr == '1) begin
                    w_state_next = S_READY;
                end
            end
            S_READY: begin
                w_flag_upd = MemWrite | MemRead;
                // A simultaneous read is dropped in favour of the write.
                if (MemWrite) begin
                    w_wr_ok     = ~w_err;
                    w_mem_we    = ~w_err;
                    w_mem_idx   = w_idx;
                    w_mem_wdata = Wdata;
                end else if (MemRead) begin
                    w_rd_go = 1'b1;
                end
            end
            default: w_state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_clr_ptr <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_ptr <= r_clr_ptr + AW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset && w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_mis    <= 1'b0;
            r_rng    <= 1'b0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_valid <= w_rd_go;
            if (w_rd_go) begin
                r_data <= w_err ? '0 : r_mem[w_idx];
            end
            if (w_flag_upd) begin
                r_mis <= r_mis | w_misalign;
                r_rng <= r_rng | w_range;
            end
            if (w_wr_ok && (r_wr_cnt != '1)) begin
                r_wr_cnt <= r_wr_cnt + CW'(1);
            end
            if (w_rd_go && !w_err && (r_rd_cnt != '1)) begin
                r_rd_cnt <= r_rd_cnt + CW'(1);
            end
        end
    end

    assign Data       = r_data;
    assign Data_Valid = r_valid;
    assign Busy       = (r_state == S_CLEAR);
    assign Misalign   = r_mis;
    assign Range_Err  = r_rng;
    assign Wr_Count   = r_wr_cnt;
    assign Rd_Count   = r_rd_cnt;

endmodule
